// File: rtl/execute_mem_pipe_fifo_if.sv
// EX->MEM handshake bundle: upstream entry fields, head fields and occupancy.
// The master modport is the producer/consumer side, the slave modport is the buffer.
interface execute_mem_pipe_fifo_if #(
    parameter int XLEN  = 32,
    parameter int RD_W  = 5,
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic            IN_VALID;
    logic            IN_READY;
    logic [XLEN-1:0] IN_PC_4;
    logic [XLEN-1:0] IN_PC_MEM;
    logic [XLEN-1:0] IN_ALU_RESULT;
    logic [XLEN-1:0] IN_RS2;
    logic [1:0]      IN_RF_WR_SEL;
    logic            IN_REGWRITE;
    logic            IN_MEMWRITE;
    logic            IN_MEMREAD2;
    logic [RD_W-1:0] IN_RD;

    logic             OUT_VALID;
    logic             OUT_READY;
    logic [XLEN-1:0]  EXEC_PC_4;
    logic [XLEN-1:0]  EXEC_PC_MEM;
    logic [XLEN-1:0]  EXEC_ALU_RESULT;
    logic [XLEN-1:0]  EXEC_RS2;
    logic [1:0]       EXEC_RF_WR_SEL;
    logic             EXEC_REGWRITE;
    logic             EXEC_MEMWRITE;
    logic             EXEC_MEMREAD2;
    logic [RD_W-1:0]  EX_MS_RD;
    logic [CNT_W-1:0] EXEC_COUNT;

    modport master (
        output IN_VALID, IN_PC_4, IN_PC_MEM, IN_ALU_RESULT, IN_RS2, IN_RF_WR_SEL,
               IN_REGWRITE, IN_MEMWRITE, IN_MEMREAD2, IN_RD, OUT_READY,
        input  IN_READY, OUT_VALID, EXEC_PC_4, EXEC_PC_MEM, EXEC_ALU_RESULT, EXEC_RS2,
               EXEC_RF_WR_SEL, EXEC_REGWRITE, EXEC_MEMWRITE, EXEC_MEMREAD2, EX_MS_RD,
               EXEC_COUNT
    );

    modport slave (
        input  IN_VALID, IN_PC_4, IN_PC_MEM, IN_ALU_RESULT, IN_RS2, IN_RF_WR_SEL,
               IN_REGWRITE, IN_MEMWRITE, IN_MEMREAD2, IN_RD, OUT_READY,
        output IN_READY, OUT_VALID, EXEC_PC_4, EXEC_PC_MEM, EXEC_ALU_RESULT, EXEC_RS2,
               EXEC_RF_WR_SEL, EXEC_REGWRITE, EXEC_MEMWRITE, EXEC_MEMREAD2, EX_MS_RD,
               EXEC_COUNT
    );
endinterface

// File: rtl/execute_mem_pipe_fifo.sv
// DEPTH-entry elastic EX->MEM buffer with valid/ready handshake, synchronous flush
// and bubble gating so an empty buffer never presents live control bits to MEM.
module execute_mem_pipe_fifo #(
    parameter int XLEN  = 32,
    parameter int RD_W  = 5,
    parameter int DEPTH = 2
) (
    input  logic EXMEM_CLOCK,
    input  logic EXMEM_RESET_N,
    input  logic EXMEM_FLUSH,
    execute_mem_pipe_fifo_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef struct packed {
        logic [XLEN-1:0] pc_4;
        logic [XLEN-1:0] pc_mem;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] rs2;
        logic [1:0]      rf_wr_sel;
        logic            regwrite;
        logic            memwrite;
        logic            memread2;
        logic [RD_W-1:0] rd;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           in_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;

    // Readiness depends on registered occupancy only, so a full buffer never
    // admits a push on the strength of a same-cycle pop.
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = bus.IN_VALID & in_ready;
    assign pop       = out_valid & bus.OUT_READY;

    assign in_entry = '{
        pc_4:       bus.IN_PC_4,
        pc_mem:     bus.IN_PC_MEM,
        alu_result: bus.IN_ALU_RESULT,
        rs2:        bus.IN_RS2,
        rf_wr_sel:  bus.IN_RF_WR_SEL,
        regwrite:   bus.IN_REGWRITE,
        memwrite:   bus.IN_MEMWRITE,
        memread2:   bus.IN_MEMREAD2,
        rd:         bus.IN_RD
    };

    // NOTE: storage has no reset; occupancy and output gating decide what is visible,
    // which keeps the array out of the reset tree.
    always_ff @(posedge EXMEM_CLOCK) begin
        if (push && !EXMEM_FLUSH) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge EXMEM_CLOCK or negedge EXMEM_RESET_N) begin
        if (!EXMEM_RESET_N) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (EXMEM_FLUSH) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the zero default comes first so the gated head never infers a latch.
    always_comb begin
        head = '0;
        if (out_valid) begin
            head = mem[rd_ptr];
        end
    end

    assign bus.IN_READY        = in_ready;
    assign bus.OUT_VALID       = out_valid;
    assign bus.EXEC_PC_4       = head.pc_4;
    assign bus.EXEC_PC_MEM     = head.pc_mem;
    assign bus.EXEC_ALU_RESULT = head.alu_result;
    assign bus.EXEC_RS2        = head.rs2;
    assign bus.EXEC_RF_WR_SEL  = head.rf_wr_sel;
    assign bus.EXEC_REGWRITE   = head.regwrite;
    assign bus.EXEC_MEMWRITE   = head.memwrite;
    assign bus.EXEC_MEMREAD2   = head.memread2;
    assign bus.EX_MS_RD        = head.rd;
    assign bus.EXEC_COUNT      = count;
endmodule
